// File: rtl/thr_pkg.sv
// Shared constants, state/requester encodings and trace arithmetic for the
// adaptive-threshold scheduler.
package thr_pkg;

  localparam int NEURON_NO  = 256;
  localparam int AW         = $clog2(NEURON_NO);
  localparam int T_FIX_WID  = 16;
  localparam int T_VAR_WID  = 12;
  localparam int DECAY_SH   = 4;
  localparam int STARVE_MAX = 8;
  localparam int SW         = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WB
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    QRY,
    SPK,
    SWP
  } req_e;

  // One time-step of decay: subtract t >> DECAY_SH, but at least 1 so that a
  // nonzero trace always shrinks and eventually reaches zero.
  function automatic logic [T_FIX_WID-1:0] decay_trace(input logic [T_FIX_WID-1:0] t);
    logic [T_FIX_WID-1:0] d;
    d = t >> DECAY_SH;
    if ((d == '0) && (t != '0)) begin
      d = T_FIX_WID'(1);
    end
    return t - d;
  endfunction

  // Spike increment, clipped at the largest representable trace.
  function automatic logic [T_FIX_WID-1:0] sat_inc(input logic [T_FIX_WID-1:0] t,
                                                   input logic [T_FIX_WID-1:0] inc);
    logic [T_FIX_WID:0] s;
    s = {1'b0, t} + {1'b0, inc};
    return s[T_FIX_WID] ? {T_FIX_WID{1'b1}} : s[T_FIX_WID-1:0];
  endfunction

endpackage

// File: rtl/thr_trace_ram.sv
// Per-neuron trace store: single port, registered read, write-first.
module thr_trace_ram
  import thr_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [T_FIX_WID-1:0] wdata,
  output logic [T_FIX_WID-1:0] rdata
);

  logic [T_FIX_WID-1:0] mem [NEURON_NO];

  // One access per cycle; on a write the new data is also returned.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/threshold_ctrl.sv
// Arbiter and scheduler sharing the trace RAM port between threshold queries,
// spike-driven increments and the per-time-step decay sweep.
module threshold_ctrl
  import thr_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ts_tick,
  input  logic                 q_valid,
  input  logic [AW-1:0]        q_addr,
  output logic                 q_ready,
  output logic                 th_valid,
  output logic [AW-1:0]        th_addr,
  output logic [T_FIX_WID-1:0] ts_efa_o_th,
  output logic [T_VAR_WID-1:0] t_thr_reg,
  input  logic                 sp_valid,
  input  logic [AW-1:0]        sp_addr,
  output logic                 sp_ready,
  input  logic                 cfg_we,
  input  logic [T_VAR_WID-1:0] cfg_thr,
  input  logic [T_FIX_WID-1:0] cfg_inc,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 overrun
);

  state_e               state;
  state_e               state_next;
  req_e                 grant;
  req_e                 rmw_sel;
  logic [AW-1:0]        rmw_addr;
  logic [AW-1:0]        init_ptr;
  logic [AW-1:0]        sweep_ptr;
  logic                 sweep_active;
  logic                 sweep_start;
  logic                 sweep_pending;
  logic                 forced;
  logic [SW-1:0]        starve_cnt;
  logic [T_FIX_WID-1:0] inc_reg;

  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [T_FIX_WID-1:0] ram_wdata;
  logic [T_FIX_WID-1:0] ram_rdata;

  // A tick outside INIT with no sweep running arms the sweep; it already
  // competes for the slot in the tick cycle itself.
  assign sweep_start   = ts_tick && (state != INIT) && !sweep_active;
  assign sweep_pending = sweep_active || sweep_start;
  assign forced        = (state == IDLE) && sweep_pending && (starve_cnt == SW'(STARVE_MAX));

  // A forced sweep slot also holds off queries so no accepted query is dropped.
  assign q_ready     = (state == IDLE) && !forced;
  assign sp_ready    = (state == IDLE) && !q_valid && !forced;
  assign busy        = (state == INIT) || sweep_active || sweep_start;
  assign ts_efa_o_th = th_valid ? ram_rdata : '0;

  thr_trace_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Slot arbitration, RAM port steering and next-state selection.
  always_comb begin
    grant      = NONE;
    state_next = state;
    ram_we     = 1'b0;
    ram_addr   = init_ptr;
    ram_wdata  = '0;
    case (state)
      INIT: begin
        ram_we   = 1'b1;
        ram_addr = init_ptr;
        if (init_ptr == AW'(NEURON_NO - 1)) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (forced) begin
          grant = SWP;
        end else if (q_valid) begin
          grant = QRY;
        end else if (sp_valid) begin
          grant = SPK;
        end else if (sweep_pending) begin
          grant = SWP;
        end
        case (grant)
          QRY:     ram_addr = q_addr;
          SPK:     ram_addr = sp_addr;
          SWP:     ram_addr = sweep_ptr;
          default: ram_addr = q_addr;
        endcase
        if ((grant == SPK) || (grant == SWP)) begin
          state_next = WB;
        end
      end
      WB: begin
        ram_we     = 1'b1;
        ram_addr   = rmw_addr;
        ram_wdata  = (rmw_sel == SPK) ? sat_inc(ram_rdata, inc_reg) : decay_trace(ram_rdata);
        state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
  end

  // State register; reset always restarts the zero-fill.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, sweep bookkeeping, starvation counter and query result strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_ptr     <= '0;
      sweep_ptr    <= '0;
      sweep_active <= 1'b0;
      sweep_done   <= 1'b0;
      overrun      <= 1'b0;
      starve_cnt   <= '0;
      rmw_sel      <= NONE;
      rmw_addr     <= '0;
      th_valid     <= 1'b0;
      th_addr      <= '0;
    end else begin
      sweep_done <= 1'b0;
      th_valid   <= (grant == QRY);

      if (state == INIT) begin
        init_ptr <= init_ptr + AW'(1);
      end

      if (grant == QRY) begin
        th_addr <= q_addr;
      end

      if ((grant == SPK) || (grant == SWP)) begin
        rmw_sel  <= grant;
        rmw_addr <= (grant == SPK) ? sp_addr : sweep_ptr;
      end

      if (ts_tick && ((state == INIT) || sweep_active)) begin
        overrun <= 1'b1;
      end

      if (sweep_start) begin
        sweep_active <= 1'b1;
        sweep_ptr    <= '0;
      end else if ((state == WB) && (rmw_sel == SWP)) begin
        sweep_ptr <= sweep_ptr + AW'(1);
        if (sweep_ptr == AW'(NEURON_NO - 1)) begin
          sweep_active <= 1'b0;
          sweep_done   <= 1'b1;
        end
      end

      if (!sweep_pending) begin
        starve_cnt <= '0;
      end else if (state == IDLE) begin
        starve_cnt <= (grant == SWP) ? '0 : starve_cnt + SW'(1);
      end
    end
  end

  // Configuration registers, writable in any state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      t_thr_reg <= '0;
      inc_reg   <= '0;
    end else if (cfg_we) begin
      t_thr_reg <= cfg_thr;
      inc_reg   <= cfg_inc;
    end
  end

endmodule

// File: tb/tb_threshold_ctrl.sv
// Directed plus randomized bench for threshold_ctrl against a trace-array model.
module tb_threshold_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ts_tick;
  logic        q_valid;
  logic [7:0]  q_addr;
  logic        q_ready;
  logic        th_valid;
  logic [7:0]  th_addr;
  logic [15:0] ts_efa_o_th;
  logic [11:0] t_thr_reg;
  logic        sp_valid;
  logic [7:0]  sp_addr;
  logic        sp_ready;
  logic        cfg_we;
  logic [11:0] cfg_thr;
  logic [15:0] cfg_inc;
  logic        busy;
  logic        sweep_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int model_mem [256];
  int model_inc;
  int model_thr;

  always #5 clk = ~clk;

  threshold_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ts_tick     (ts_tick),
    .q_valid     (q_valid),
    .q_addr      (q_addr),
    .q_ready     (q_ready),
    .th_valid    (th_valid),
    .th_addr     (th_addr),
    .ts_efa_o_th (ts_efa_o_th),
    .t_thr_reg   (t_thr_reg),
    .sp_valid    (sp_valid),
    .sp_addr     (sp_addr),
    .sp_ready    (sp_ready),
    .cfg_we      (cfg_we),
    .cfg_thr     (cfg_thr),
    .cfg_inc     (cfg_inc),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .overrun     (overrun)
  );

  function automatic int sat_add(input int t, input int inc);
    return (t + inc > 65535) ? 65535 : t + inc;
  endfunction

  function automatic int decay_ref(input int t);
    int d;
    d = t / 16;
    if (t != 0 && d < 1) d = 1;
    return t - d;
  endfunction

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 8'd7;
      1:       return 8'd100;
      2:       return 8'($urandom_range(0, 15));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ts_tick = 1'b0;
    q_valid = 1'b0;
    sp_valid = 1'b0;
    cfg_we = 1'b0;
    repeat (3) step();
    check_output("rst_th_valid", th_valid, 0);
    check_output("rst_q_ready", q_ready, 0);
    check_output("rst_sp_ready", sp_ready, 0);
    check_output("rst_sweep_done", sweep_done, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_t_thr_reg", t_thr_reg, 0);
    check_output("rst_trace_out", ts_efa_o_th, 0);
    reset_n = 1'b1;
    foreach (model_mem[i]) model_mem[i] = 0;
    model_inc = 0;
    model_thr = 0;
  endtask

  task automatic wait_init(input bit tick_in_init);
    int n;
    int ready_bad;
    n = 0;
    ready_bad = 0;
    while (busy && n < 400) begin
      if (q_ready || sp_ready) ready_bad++;
      ts_tick = (tick_in_init && n == 50);
      step();
      n++;
    end
    ts_tick = 1'b0;
    check_output("init_busy_cycles", n, 256);
    check_output("init_ready_low", ready_bad, 0);
  endtask

  task automatic do_query(input logic [7:0] a, input string tag);
    int n;
    q_valid = 1'b1;
    q_addr = a;
    #1;
    n = 0;
    while (!q_ready && n < 20) begin
      step();
      n++;
    end
    check_output({tag, "_wait"}, n < 20, 1);
    step();
    q_valid = 1'b0;
    check_output({tag, "_th_valid"}, th_valid, 1);
    check_output({tag, "_th_addr"}, th_addr, a);
    check_output({tag, "_trace"}, ts_efa_o_th, model_mem[a]);
    check_output({tag, "_thr"}, t_thr_reg, model_thr);
  endtask

  task automatic do_spike(input logic [7:0] a);
    int n;
    sp_valid = 1'b1;
    sp_addr = a;
    #1;
    n = 0;
    while (!sp_ready && n < 20) begin
      step();
      n++;
    end
    check_output("spike_wait", n < 20, 1);
    step();
    sp_valid = 1'b0;
    model_mem[a] = sat_add(model_mem[a], model_inc);
    step();
  endtask

  task automatic do_cfg(input logic [11:0] thr, input logic [15:0] inc);
    cfg_we = 1'b1;
    cfg_thr = thr;
    cfg_inc = inc;
    step();
    cfg_we = 1'b0;
    model_thr = thr;
    model_inc = inc;
    check_output("cfg_t_thr_reg", t_thr_reg, thr);
  endtask

  task automatic sweep_uncontended();
    int k;
    ts_tick = 1'b1;
    step();
    ts_tick = 1'b0;
    k = 1;
    check_output("sweep_busy", busy, 1);
    while (!sweep_done && k < 2000) begin
      step();
      k++;
    end
    check_output("sweep_done_cycle", k, 512);
    check_output("sweep_busy_fall", busy, 0);
    step();
    check_output("sweep_done_pulse", sweep_done, 0);
    foreach (model_mem[i]) model_mem[i] = decay_ref(model_mem[i]);
  endtask

  task automatic sweep_contended();
    int orig [256];
    int g, cyc, stall, max_stall, runs, since, bad, expv;
    logic [7:0] a;
    logic granted;
    orig = model_mem;
    q_valid = 1'b1;
    q_addr = pick_addr();
    ts_tick = 1'b1;
    #1;
    g = 0; cyc = 0; stall = 0; max_stall = 0; runs = 0; since = 0; bad = 0; expv = 0;
    while (cyc < 3000) begin
      granted = q_ready;
      a = q_addr;
      if (granted) begin
        expv = (int'(a) < g / 8) ? decay_ref(orig[a]) : orig[a];
        g++;
        since++;
        stall = 0;
      end else begin
        stall++;
        if (stall > max_stall) max_stall = stall;
        if (stall == 1) begin
          runs++;
          if (since != 8) bad++;
          since = 0;
        end
      end
      step();
      ts_tick = 1'b0;
      cyc++;
      if (granted) begin
        check_output("cont_th_valid", th_valid, 1);
        check_output("cont_trace", ts_efa_o_th, expv);
      end
      if (sweep_done) break;
      q_addr = pick_addr();
      #1;
    end
    q_valid = 1'b0;
    check_output("cont_done_cycle", cyc, 2560);
    check_output("cont_sweep_slots", runs, 256);
    check_output("cont_gap_not_8", bad, 0);
    check_output("cont_max_stall", max_stall, 2);
    check_output("cont_busy_fall", busy, 0);
    foreach (model_mem[i]) model_mem[i] = decay_ref(orig[i]);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    int op;
    logic [7:0] ra;
    q_addr = '0;
    sp_addr = '0;
    cfg_thr = '0;
    cfg_inc = '0;
    do_reset();
    wait_init(1'b0);
    check_output("init_overrun", overrun, 0);

    $display("[TB] first query after init");
    do_query(8'd5, "q5");
    step();
    check_output("q5_one_cycle", th_valid, 0);

    $display("[TB] config and spikes");
    do_cfg(12'h199, 16'h0100);
    repeat (3) do_spike(8'd7);
    do_query(8'd7, "q7");
    check_output("q7_value", ts_efa_o_th, 16'h0300);
    do_cfg(12'h199, 16'hFF80);
    do_spike(8'd9);
    do_cfg(12'h199, 16'h0100);
    do_spike(8'd9);
    do_query(8'd9, "q9");
    check_output("q9_saturate", ts_efa_o_th, 16'hFFFF);

    $display("[TB] randomized queries/spikes/config");
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      ra = 8'($urandom_range(0, 15));
      if (op < 5) do_query(ra, "rand_q");
      else if (op < 9) do_spike(ra);
      else do_cfg(12'($urandom_range(0, 4095)), 16'($urandom_range(0, 16'h3FFF)));
    end

    $display("[TB] uncontended sweep");
    do_cfg(12'h199, 16'h0100);
    do_spike(8'd100);
    do_cfg(12'h199, 16'h000F);
    do_spike(8'd101);
    do_cfg(12'h199, 16'h0400);
    do_spike(8'd30);
    do_spike(8'd200);
    sweep_uncontended();
    do_query(8'd100, "sw100");
    check_output("sw100_value", ts_efa_o_th, 16'h00F0);
    do_query(8'd101, "sw101");
    check_output("sw101_value", ts_efa_o_th, 16'h000E);
    do_query(8'd102, "sw102");
    check_output("sw102_value", ts_efa_o_th, 16'h0000);
    do_query(8'd9, "sw9");

    $display("[TB] sweep under continuous queries");
    sweep_contended();
    do_query(8'd200, "cont200");

    $display("[TB] overrun");
    check_output("ovr_before", overrun, 0);
    ts_tick = 1'b1;
    step();
    ts_tick = 1'b0;
    repeat (100) step();
    ts_tick = 1'b1;
    step();
    ts_tick = 1'b0;
    check_output("ovr_set", overrun, 1);
    pulses = 0;
    for (int i = 0; i < 1500; i++) begin
      if (sweep_done) pulses++;
      step();
    end
    check_output("ovr_single_sweep", pulses, 1);
    foreach (model_mem[i]) model_mem[i] = decay_ref(model_mem[i]);
    do_query(8'd7, "ovr7");
    do_query(8'd100, "ovr100");

    $display("[TB] reset mid-sweep");
    ts_tick = 1'b1;
    step();
    ts_tick = 1'b0;
    repeat (100) step();
    do_reset();
    check_output("rst2_overrun", overrun, 0);
    wait_init(1'b1);
    check_output("init_tick_overrun", overrun, 1);
    repeat (3) step();
    check_output("init_tick_no_sweep", busy, 0);
    do_query(8'd7, "rst7");
    do_query(8'd9, "rst9");
    do_query(8'd200, "rst200");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
